fft_output_reorder: RTL and testbench
=====================================

Name: fft_output_reorder

Overview:
- Sits at the output end of the 32-point FFT pipeline, after the last butterfly stage.
- Accepts complex samples in bit-reversed index order on the stage valid/data stream and re-emits each 32-sample frame in natural order.
- Uses a ping-pong buffer: one bank is written while the other is read, so contiguous input frames give contiguous output frames with no backpressure.

Parameters:
- N, 32: frame length; must be a power of two.
- LOG2N, 5: log2(N); address width.
- DW, 16: width of each real and imaginary component, two's complement.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  input sample qualifier; a sample is accepted on each rising edge with valid_i=1.
- data_in_r  in  DW  real part of the input sample, in bit-reversed order within the frame.
- data_in_i  in  DW  imaginary part of the input sample.
- valid_o  out  1  output sample qualifier.
- sof_o  out  1  high with valid_o on natural index 0 of each frame.
- data_out_r  out  DW  real part of the output sample, natural order.
- data_out_i  out  DW  imaginary part of the output sample.

Behaviour:
- Reset (asynchronous, effective immediately):
  - valid_o=0, sof_o=0, data_out_r=0, data_out_i=0.
  - Write counter=0, write bank=0, read index=0, read FSM=IDLE, both bank_full flags=0.
  - Buffer RAM contents are not reset.
- Write side:
  - The k-th accepted sample of a frame (k=0..N-1) is stored at bank[wbank][k].
  - The write counter advances only on accepted samples; gaps in valid_i are allowed and do not affect stored data.
  - On accepting k=N-1: set bank_full[wbank], toggle wbank, wrap the counter to 0.
- Read side: output index n reads bank[rbank][bitrev(n)].
- Read FSM states: IDLE, READ.
  - IDLE -> READ when any bank_full flag is set, taking the lowest-numbered full bank that is next in sequence. rbank alternates 0,1,0,...
  - In READ, one output per cycle, n=0..N-1 with no gaps.
  - At n=N-1, clear bank_full[rbank]. If the other bank is full (including the case where it becomes full on the same edge), go directly to n=0 of that bank, giving back-to-back output. Otherwise go to IDLE.
- Output registers:
  - data_out_r, data_out_i, valid_o and sof_o are registered.
  - If the 32nd sample of a frame is accepted on edge E, output n appears after edge E+1+n, so first-out latency is 1 cycle after the last-in edge.
  - Outside READ: valid_o=0, sof_o=0, and data_out holds its last value.
- Width: pass-through only, no arithmetic or rounding; bits are preserved exactly.
- Collision freedom:
  - The writer needs at least N edges per frame, so the read of bank A (last load at E+N) always finishes before the writer's first rewrite of A (earliest E+N+1).
  - The bench asserts that the writer never writes a bank whose bank_full flag is set. Should this ever occur, the sample is still written and the flag remains set (overflow is not flagged).
- Partial frame: if valid_i stops mid-frame, the samples are held indefinitely and no output is produced until the frame completes.
- Reset mid-frame or mid-read: the partial frame is discarded, and valid_o drops asynchronously.

Decomposition:
- Shared package fft_pkg holds FFT_N=32, FFT_LOG2N=5, FFT_DW=16, and a bitrev function parameterised by LOG2N.
- One sub-module, fft_pingpong_ram: 2 x N x 2*DW, one write port and one read port.
  - Write happens on the clock edge.
  - Read is combinational from the read address; the output register lives in the parent.

Test Plan:
- Single frame, contiguous valid: sample k carries data_in_r=bitrev5(k)*8 and data_in_i=-bitrev5(k)*8. Expect 32 contiguous valid_o with data_out_r=0,8,...,248, data_out_i=0,-8,...,-248. sof_o is high on the first output only; the first output appears 1 cycle after the last-input edge.
- Two back-to-back frames, 64 contiguous valid: frame 2 uses values offset by +1000. Expect 64 contiguous valid_o with no gap and sof_o at outputs 0 and 32. Frame 2 reads 1000,1008,...,1248.
- Gapped input, valid_i alternating 1/0 for 64 cycles carrying frame 1: expect output identical to scenario 1, starting 1 cycle after the 32nd accepted edge.
- Reset asserted after 10 accepted samples, then a full frame: only the full frame is output, valid_o count=32, and the values match scenario 1.
- Reset asserted while output n=5 is on the bus: valid_o and data_out fall to 0 without waiting for a clock edge, and no further outputs appear until a new full frame is accepted.
- valid_i held at 0 for 200 cycles after reset, or a partial frame of 31 samples: valid_o stays 0 throughout.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, read-FSM state type and bit-reversal helper for the FFT pipeline.
package fft_pkg;
    localparam int FFT_N       = 32;
    localparam int FFT_LOG2N   = 5;
    localparam int FFT_DW      = 16;
    localparam int BITREV_MAXW = 16;

    typedef enum logic {IDLE, READ} rd_state_e;

    // Reverse the low lg bits of a; lg may be anything up to BITREV_MAXW.
    function automatic logic [BITREV_MAXW-1:0] bitrev(input logic [BITREV_MAXW-1:0] a,
                                                      input int unsigned lg);
        logic [BITREV_MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < BITREV_MAXW; i++) r[i] = a[BITREV_MAXW-1-i];
        return r >> (BITREV_MAXW - lg);
    endfunction
endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store: synchronous write port, combinational read port.
module fft_pingpong_ram
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N,
    parameter int W     = 2*FFT_DW
) (
    input  logic             clk,
    input  logic             we,
    input  logic             wbank,
    input  logic [LOG2N-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic             rbank,
    input  logic [LOG2N-1:0] raddr,
    output logic [W-1:0]     rdata
);
    logic [W-1:0] mem [2*N];

    always_ff @(posedge clk) begin
        if (we) mem[{wbank, waddr}] <= wdata;
    end

    assign rdata = mem[{rbank, raddr}];
endmodule

// File: rtl/fft_output_reorder.sv
// Reorders bit-reversed FFT output frames into natural order through a ping-pong buffer.
module fft_output_reorder
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N,
    parameter int DW    = FFT_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    input  logic [DW-1:0] data_in_r,
    input  logic [DW-1:0] data_in_i,
    output logic          valid_o,
    output logic          sof_o,
    output logic [DW-1:0] data_out_r,
    output logic [DW-1:0] data_out_i
);
    logic [LOG2N-1:0] wcnt, ridx, raddr;
    logic             wbank, rbank;
    logic [1:0]       bank_full, set_vec, clr_vec, full_seen;
    logic [2*DW-1:0]  rdata;
    logic             wr_last, rd_last;
    rd_state_e        state;

    assign wr_last   = valid_i && (wcnt == LOG2N'(N-1));
    assign rd_last   = (state == READ) && (ridx == LOG2N'(N-1));
    assign set_vec   = wr_last ? (2'b01 << wbank) : 2'b00;
    assign clr_vec   = rd_last ? (2'b01 << rbank) : 2'b00;
    // A bank completing on this edge counts as full, giving one-cycle latency and gapless handover.
    assign full_seen = bank_full | set_vec;
    assign raddr     = LOG2N'(bitrev(BITREV_MAXW'(ridx), LOG2N));

    fft_pingpong_ram #(.N(N), .LOG2N(LOG2N), .W(2*DW)) u_ram (
        .clk   (clk),
        .we    (valid_i),
        .wbank (wbank),
        .waddr (wcnt),
        .wdata ({data_in_r, data_in_i}),
        .rbank (rbank),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt      <= '0;
            wbank     <= 1'b0;
            bank_full <= 2'b00;
        end else begin
            bank_full <= full_seen & ~clr_vec;
            if (valid_i) begin
                wcnt <= wr_last ? '0 : wcnt + LOG2N'(1);
                if (wr_last) wbank <= ~wbank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ridx       <= '0;
            rbank      <= 1'b0;
            valid_o    <= 1'b0;
            sof_o      <= 1'b0;
            data_out_r <= '0;
            data_out_i <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid_o <= 1'b0;
                    sof_o   <= 1'b0;
                    if (full_seen[rbank]) begin
                        state <= READ;
                        ridx  <= '0;
                    end
                end
                READ: begin
                    valid_o    <= 1'b1;
                    sof_o      <= (ridx == '0);
                    data_out_r <= rdata[2*DW-1:DW];
                    data_out_i <= rdata[DW-1:0];
                    if (rd_last) begin
                        rbank <= ~rbank;
                        ridx  <= '0;
                        if (!full_seen[~rbank]) state <= IDLE;
                    end else begin
                        ridx <= ridx + LOG2N'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_output_reorder.sv
// Scoreboard bench: stimulus queues expected natural-order samples, a monitor checks them on valid_o.
module tb_fft_output_reorder;
    localparam int N = 32;

    logic        clk, rst_n, valid_i, valid_o, sof_o;
    logic [15:0] data_in_r, data_in_i, data_out_r, data_out_i;

    typedef struct {
        int          cyc;
        logic        sof;
        logic [15:0] re;
        logic [15:0] im;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   last_edge  = 0;

    fft_output_reorder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .data_in_r  (data_in_r),
        .data_in_i  (data_in_i),
        .valid_o    (valid_o),
        .sof_o      (sof_o),
        .data_out_r (data_out_r),
        .data_out_i (data_out_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bitrev5(input int k);
        int r = 0;
        for (int i = 0; i < 5; i++) if (k[i]) r |= 1 << (4 - i);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid_o) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_output at cycle %0d: got r=%0d i=%0d sof=%0b, expected no output",
                         cyc, $signed(data_out_r), $signed(data_out_i), sof_o);
            end else begin
                e = exp_q.pop_front();
                if (cyc !== e.cyc || sof_o !== e.sof || data_out_r !== e.re || data_out_i !== e.im) begin
                    mismatched++;
                    $display("FAIL out_sample: got cyc=%0d sof=%0b r=%0d i=%0d, expected cyc=%0d sof=%0b r=%0d i=%0d",
                             cyc, sof_o, $signed(data_out_r), $signed(data_out_i),
                             e.cyc, e.sof, $signed(e.re), $signed(e.im));
                end
            end
        end
        if (rst_n && valid_i) begin
            compared++;
            if (dut.bank_full[dut.wbank]) begin
                mismatched++;
                $display("FAIL bank_overwrite at cycle %0d: got write into full bank %0d, expected free bank",
                         cyc, dut.wbank);
            end
        end
    end

    // Sample k carries off+8*bitrev5(k), so natural output n must read off+8*n.
    task automatic send(input int off, input int cnt, input bit gap);
        int b;
        for (int k = 0; k < cnt; k++) begin
            @(negedge clk);
            valid_i   = 1'b1;
            b         = bitrev5(k);
            data_in_r = 16'(off + 8*b);
            data_in_i = 16'(-(off + 8*b));
            if (k == N-1) begin
                last_edge = cyc + 1;
                for (int n = 0; n < N; n++)
                    exp_q.push_back('{last_edge + 1 + n, n == 0, 16'(off + 8*n), 16'(-(off + 8*n))});
            end
            if (gap) begin
                @(negedge clk);
                valid_i = 1'b0;
            end
        end
    endtask

    task automatic stop_input();
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        compared++;
        if (exp_q.size() > 0) begin
            mismatched++;
            $display("FAIL drain_timeout: got %0d outputs pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; valid_i = 1'b0; data_in_r = '0; data_in_i = '0;
        repeat (2) @(negedge clk);
        check("rst_valid_o", valid_o, 0);
        check("rst_sof_o", sof_o, 0);
        check("rst_data_out_r", data_out_r, 0);
        check("rst_data_out_i", data_out_i, 0);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);

        send(0, N, 1'b0); stop_input(); drain();

        send(0, N, 1'b0); send(1000, N, 1'b0); stop_input(); drain();

        send(0, N, 1'b1); drain();

        send(0, 10, 1'b0);
        @(negedge clk);
        valid_i = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(0, N, 1'b0); stop_input(); drain();

        send(0, N, 1'b0); stop_input();
        guard = 0;
        while (cyc < last_edge + 6 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("n5_valid_o", valid_o, 1);
        check("n5_data_out_r", data_out_r, 40);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid_o", valid_o, 0);
        check("async_rst_sof_o", sof_o, 0);
        check("async_rst_data_out_r", data_out_r, 0);
        check("async_rst_data_out_i", data_out_i, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);

        send(0, N-1, 1'b0); stop_input();
        repeat (100) @(negedge clk);
        check("partial_pending", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
